// File: rtl/stepper_speed_ramp.sv
// Ramped speed/direction profile generator feeding the stepper coil driver.
// Speed moves at most one step per ramp tick; reversals decelerate to zero first.
module stepper_speed_ramp #(
  parameter int unsigned RAMP_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] target_speed,
  input  logic       target_dir,
  output logic [2:0] speed_out,
  output logic       dir_out,
  output logic       moving,
  output logic       at_target,
  output logic [2:0] state
);

  localparam int unsigned PW = $clog2(RAMP_DIV);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCEL   = 3'd1,
    CRUISE  = 3'd2,
    DECEL   = 3'd3,
    REVERSE = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_nxt;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic [2:0]    eff_target;
  logic [2:0]    speed_nxt;
  logic          dir_nxt;

  assign eff_target = enable ? target_speed : 3'd0;
  assign tick       = (pcnt == PW'(RAMP_DIV - 1));

  always_comb begin
    speed_nxt = speed_out;
    dir_nxt   = dir_out;
    if (dir_out != target_dir) begin
      // A reversal only flips direction once stopped, and never on a speed-change edge.
      if (speed_out == 3'd0)
        dir_nxt = target_dir;
      else if (tick)
        speed_nxt = speed_out - 3'd1;
    end else if (tick) begin
      if (speed_out < eff_target)
        speed_nxt = speed_out + 3'd1;
      else if (speed_out > eff_target)
        speed_nxt = speed_out - 3'd1;
    end
  end

  // State reports the classification of the outputs being loaded this edge.
  always_comb begin
    state_nxt = IDLE;
    if (dir_nxt != target_dir)
      state_nxt = REVERSE;
    else if (speed_nxt == 3'd0 && eff_target == 3'd0)
      state_nxt = IDLE;
    else if (speed_nxt < eff_target)
      state_nxt = ACCEL;
    else if (speed_nxt == eff_target)
      state_nxt = CRUISE;
    else
      state_nxt = DECEL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt      <= '0;
      speed_out <= '0;
      dir_out   <= 1'b0;
      state_q   <= IDLE;
    end else begin
      pcnt      <= tick ? '0 : pcnt + 1'b1;
      speed_out <= speed_nxt;
      dir_out   <= dir_nxt;
      state_q   <= state_nxt;
    end
  end

  assign state     = state_q;
  assign moving    = (speed_out != 3'd0);
  assign at_target = (speed_out == eff_target) &&
                     ((dir_out == target_dir) || (eff_target == 3'd0));

endmodule
